mem_write_ctrl: RTL
===================

MEM_WRITE_CTRL -- requirements
Module: mem_write_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, sets the width of the memory word address.
REQ-002 Parameter BASE_ADDR, default 0, sets the first word address written after reset.
REQ-003 Port clk_mem, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: permits FIFO draining when high.
REQ-006 Port flush, input, 1 bit: requests a write of a partially assembled word.
REQ-007 Port fifo_empty, input, 1 bit: upstream FIFO empty flag, read-clock domain.
REQ-008 Port fifo_data, input, 8 bits: FIFO read data, valid in the same cycle that fifo_rd_en is high and fifo_empty is low.
REQ-009 Port fifo_rd_en, output, 1 bit: FIFO pop strobe.
REQ-010 Port mem_req, output, 1 bit: memory write request.
REQ-011 Port mem_addr, output, ADDR_W bits: word address.
REQ-012 Port mem_wdata, output, 32 bits: write data; byte lane 0 is [7:0].
REQ-013 Port mem_be, output, 4 bits: byte enables, one per lane.
REQ-014 Port mem_ack, input, 1 bit: memory accepted the write.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 Port word_count, output, 16 bits: number of completed memory writes.

Function
REQ-017 The block SHALL implement three states: IDLE, FILL and WRITE.
REQ-018 IDLE -> FILL on the first edge at which enable is high.
REQ-019 fifo_rd_en SHALL be combinational and equal to (state==FILL) && enable && !fifo_empty; it is never high while fifo_empty is high.
REQ-020 On each edge with fifo_rd_en high, fifo_data SHALL be stored into byte lane byte_cnt (2-bit counter, lanes filled 0,1,2,3 in order) and byte_cnt SHALL increment.
REQ-021 Capturing lane 3 SHALL move FILL -> WRITE on the same edge, with mem_be=4'b1111; the first mem_req rises one cycle after the fourth pop.
REQ-022 In FILL, if flush is high, fifo_rd_en is low and byte_cnt>0, the block SHALL move to WRITE with mem_be containing ones for lanes 0..byte_cnt-1 only (e.g. 2 bytes -> 4'b0011).
REQ-023 When flush and a pop coincide, the pop SHALL take priority, and flush SHALL be evaluated again on the next edge if it is still high.
REQ-024 Flush with byte_cnt==0 SHALL be ignored.
REQ-025 Unfilled lanes of mem_wdata SHALL read as 0.
REQ-026 In FILL with enable low: stay in FILL holding the partial word (no pops) if byte_cnt>0; go to IDLE if byte_cnt==0. A flush is still honoured while enable is low.
REQ-027 In WRITE, mem_req SHALL be high and mem_addr, mem_wdata and mem_be SHALL be held stable until mem_ack is sampled high; no pops occur in WRITE.
REQ-028 On an edge with mem_ack high in WRITE, the block SHALL:
- increment mem_addr modulo 2^ADDR_W (wrapping to 0, not to BASE_ADDR);
- increment word_count, saturating at 16'hFFFF;
- clear byte_cnt, mem_wdata and mem_be;
- drop mem_req;
- go to FILL if enable is high, else to IDLE.
REQ-029 mem_ack sampled outside WRITE SHALL have no effect.

Reset
REQ-030 While reset_n is low, the outputs SHALL be: state IDLE, fifo_rd_en=0, mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0, mem_be=0, busy=0, word_count=0, byte_cnt=0.
REQ-031 Reset asserted mid-WRITE or mid-FILL SHALL immediately abandon the word; no write is replayed after reset.

Verification
REQ-032 FIFO holds 8'h11,22,33,44, enable=1, mem_ack returned one cycle after mem_req -> exactly four fifo_rd_en pulses, then mem_req with mem_addr=0, mem_wdata=32'h44332211, mem_be=4'hF; word_count=1 after the ack.
REQ-033 Two bytes 8'hAA,BB are popped, then the FIFO goes empty and flush pulses -> mem_wdata=32'h0000BBAA, mem_be=4'b0011.
REQ-034 mem_ack held low for 10 cycles in WRITE -> mem_req, mem_addr, mem_wdata and mem_be stay constant and fifo_rd_en stays 0 throughout.
REQ-035 With ADDR_W=2, five full words are written -> mem_addr sequence 0,1,2,3,0.
REQ-036 reset_n pulsed low during WRITE -> all outputs at their reset values immediately; after release, the next write goes to BASE_ADDR with word_count starting at 1.
REQ-037 flush and a pop in the same cycle at byte_cnt=1 -> the byte is stored in lane 1, and the write issues with mem_be=4'b0011 (flush still held) or after further bytes (flush dropped).

Source files
------------

// File: rtl/mem_write_ctrl.sv
// rtl/mem_write_ctrl.sv - packs FIFO bytes into 32-bit words and issues acked memory writes
module mem_write_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_data,
    output logic              fifo_rd_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              busy,
    output logic [15:0]       word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] byte_cnt;
    logic       pop;
    logic       do_flush;
    logic       do_ack;

    // A pop always wins over a flush in the same cycle; the flush is re-evaluated next edge.
    assign pop        = (state == FILL) && enable && !fifo_empty;
    assign do_flush   = (state == FILL) && !pop && flush && (byte_cnt != 2'd0);
    assign do_ack     = (state == WRITE) && mem_ack;
    assign fifo_rd_en = pop;
    assign mem_req    = (state == WRITE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (pop && (byte_cnt == 2'd3)) begin
                    state_nxt = WRITE;
                end else if (do_flush) begin
                    state_nxt = WRITE;
                end else if (!enable && (byte_cnt == 2'd0)) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_nxt = enable ? FILL : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt   <= 2'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            mem_addr   <= BASE;
            word_count <= 16'd0;
        end else begin
            if (pop) begin
                mem_wdata[{byte_cnt, 3'b000} +: 8] <= fifo_data;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_be <= 4'b1111;
                end
            end else if (do_flush) begin
                // Enables only the lanes captured so far: 1 byte -> 0001, 2 -> 0011, 3 -> 0111.
                mem_be <= (4'b0001 << byte_cnt) - 4'b0001;
            end
            if (do_ack) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                byte_cnt  <= 2'd0;
                mem_wdata <= 32'd0;
                mem_be    <= 4'd0;
                if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end
        end
    end

endmodule
